spi_regfile_rw: RTL

//  SPI Mode 0 (CPOL=0, CPHA=0) peripheral with a parametrised register bank and read-back over CIPO.

---
 rtl/spi_regfile_rw_pkg.sv | 23 ++
 rtl/spi_sync_edge.sv | 42 ++++
 rtl/spi_regfile_rw.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_regfile_rw_pkg.sv
// ============================================================================
// Module  : spi_regfile_rw_pkg
// Brief   : Shared frame-direction codes and FSM state encodings for spi_regfile_rw
// Revision: 1.0
// ============================================================================
`default_nettype none

package spi_regfile_rw_pkg;

    localparam logic SPI_WRITE = 1'b1;
    localparam logic SPI_READ  = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_DATA   = 3'd2,
        S_DONE   = 3'd3,
        S_COMMIT = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// Module  : spi_sync_edge
// Brief   : Multi-stage synchroniser with rise/fall decode on the last two stages
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    // Stage STAGES-2 holds the newer sample, STAGES-1 the older one.
    assign lvl  = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-2] & ~sync_q[STAGES-1];
    assign fall = ~sync_q[STAGES-2] & sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/spi_regfile_rw.sv
// ============================================================================
// Module  : spi_regfile_rw
// Brief   : SPI mode-0 peripheral with read/write register bank, write strobes, frame errors
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_regfile_rw
    import spi_regfile_rw_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         nCS,
    input  logic                         SCLK,
    input  logic                         COPI,
    output logic                         CIPO,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         frame_err
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_ADDR_END = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_OVER     = CNT_W'(FRAME_W + 1);

    logic ncs_lvl, ncs_rise, ncs_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, copi_rise, copi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ncs_sync (
        .clk(clk), .rst_n(rst_n), .din(nCS), .lvl(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .din(SCLK), .lvl(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_copi_sync (
        .clk(clk), .rst_n(rst_n), .din(COPI), .lvl(copi_lvl), .rise(copi_rise), .fall(copi_fall)
    );

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [FRAME_W-1:0]      rx_q, rx_d, rx_shift;
    logic [DATA_W-1:0]       tx_q, tx_d, rd_word;
    logic                    rw_q, rw_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    load_q, load_d;
    logic                    pend_q, pend_d;
    logic                    armed_q, armed_d;
    logic [SYNC_STAGES-1:0]  fill_q, fill_d;
    logic                    cipo_q, cipo_d;
    logic                    oe_q, oe_d;
    logic [NUM_REGS-1:0]     strobe_q, strobe_d;
    logic                    err_q, err_d;

    logic unused_sig;
    assign unused_sig = ^{sclk_lvl, copi_rise, copi_fall, rx_q[FRAME_W-1]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        load_d   = 1'b0;
        pend_d   = pend_q;
        strobe_d = '0;
        err_d    = 1'b0;
        // A frame may only start once nCS has been seen high after reset.
        fill_d   = {fill_q[SYNC_STAGES-2:0], 1'b1};
        armed_d  = armed_q | (fill_q[SYNC_STAGES-1] & ncs_lvl);
        cnt_inc  = (cnt_q == CNT_OVER) ? cnt_q : cnt_q + CNT_W'(1);
        rx_shift = {rx_q[FRAME_W-2:0], copi_lvl};
        rd_word  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                rd_word = regs_out[i*DATA_W +: DATA_W];
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (armed_q && (ncs_fall || pend_q)) begin
                    state_d = S_ADDR;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            S_ADDR: begin
                if (sclk_rise) begin
                    rx_d  = rx_shift;
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_ADDR_END) begin
                        state_d = S_DATA;
                        rw_d    = rx_shift[ADDR_W];
                        addr_d  = rx_shift[ADDR_W-1:0];
                        load_d  = (rx_shift[ADDR_W] == SPI_READ);
                    end
                end
            end
            S_DATA: begin
                // The fall right after the last address bit must keep the MSB in place.
                if (load_q) begin
                    tx_d = rd_word;
                end else if (sclk_fall && (cnt_q != CNT_ADDR_END)) begin
                    tx_d = {tx_q[DATA_W-2:0], 1'b0};
                end
                if (sclk_rise) begin
                    rx_d  = rx_shift;
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_FULL) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (sclk_rise) begin
                    cnt_d = CNT_OVER;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
                if (ncs_fall) begin
                    pend_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // nCS rise overrides any SCLK edge seen on the same clock.
        if (ncs_rise && (state_q != S_IDLE) && (state_q != S_COMMIT)) begin
            state_d = S_COMMIT;
            cnt_d   = cnt_q;
            rx_d    = rx_q;
            tx_d    = tx_q;
            rw_d    = rw_q;
            addr_d  = addr_q;
            load_d  = 1'b0;
            if (cnt_q == CNT_FULL) begin
                if (rw_q == SPI_WRITE) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        strobe_d[i] = (addr_q == ADDR_W'(i));
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end

        oe_d   = (state_q == S_DATA) && (state_d == S_DATA) && (rw_q == SPI_READ);
        cipo_d = oe_d & tx_d[DATA_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rx_q     <= '0;
            tx_q     <= '0;
            rw_q     <= SPI_READ;
            addr_q   <= '0;
            load_q   <= 1'b0;
            pend_q   <= 1'b0;
            armed_q  <= 1'b0;
            fill_q   <= '0;
            cipo_q   <= 1'b0;
            oe_q     <= 1'b0;
            strobe_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            load_q   <= load_d;
            pend_q   <= pend_d;
            armed_q  <= armed_d;
            fill_q   <= fill_d;
            cipo_q   <= cipo_d;
            oe_q     <= oe_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
        end
    end

    // Strobe is high during COMMIT; the register takes the data at the end of it.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
        logic [DATA_W-1:0] reg_q, reg_d;
        logic              we;

        assign we = (state_q == S_COMMIT) & strobe_q[gi];

        always_comb begin
            reg_d = reg_q;
            if (we) begin
                reg_d = rx_q[DATA_W-1:0];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                reg_q <= '0;
            end else begin
                reg_q <= reg_d;
            end
        end

        assign regs_out[gi*DATA_W +: DATA_W] = reg_q;
    end

    assign CIPO      = cipo_q;
    assign cipo_oe   = oe_q;
    assign wr_strobe = strobe_q;
    assign frame_err = err_q;

endmodule

`default_nettype wire
